// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one adder among NUM_REQ requesters; define ADDER_ARB_SKID_EN for a 2-entry output FIFO.
module adder_share_arb_add #(
    parameter int DATA_IN_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH = 8,
    parameter bit TAKE_MSB       = 1
) (
    input  logic [DATA_IN_WIDTH-1:0]  a,
    input  logic [DATA_IN_WIDTH-1:0]  b,
    output logic [DATA_OUT_WIDTH-1:0] y
);
    logic [DATA_IN_WIDTH:0] s;
    assign s = {1'b0, a} + {1'b0, b};
    assign y = DATA_OUT_WIDTH'(TAKE_MSB ? s >> (DATA_IN_WIDTH + 1 - DATA_OUT_WIDTH) : s);
endmodule

module adder_share_arb #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH = 8,
    parameter bit TAKE_MSB       = 1,
    parameter int ID_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 in_valid,
    output logic [NUM_REQ-1:0]                 in_ready,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   data_in_1,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   data_in_2,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_OUT_WIDTH-1:0]          data_out,
    output logic [ID_WIDTH-1:0]                out_id
);
    logic [ID_WIDTH-1:0]       rr_ptr, cand;
    logic                      found, accept_ok, xfer;
    logic [DATA_OUT_WIDTH-1:0] sum_res;

    always_comb begin
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++)
            if (!found && in_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                cand  = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            end
    end

    assign xfer     = found && accept_ok && !rst;
    assign in_ready = xfer ? NUM_REQ'(1) << cand : '0;

    adder_share_arb_add #(
        .DATA_IN_WIDTH (DATA_IN_WIDTH),
        .DATA_OUT_WIDTH(DATA_OUT_WIDTH),
        .TAKE_MSB      (TAKE_MSB)
    ) u_add (
        .a(data_in_1[cand*DATA_IN_WIDTH +: DATA_IN_WIDTH]),
        .b(data_in_2[cand*DATA_IN_WIDTH +: DATA_IN_WIDTH]),
        .y(sum_res)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            rr_ptr <= '0;
        else if (xfer)
            rr_ptr <= (cand == ID_WIDTH'(NUM_REQ - 1)) ? '0 : cand + 1'b1;

`ifdef ADDER_ARB_SKID_EN
    logic [DATA_OUT_WIDTH-1:0] fifo_d  [2];
    logic [ID_WIDTH-1:0]       fifo_id [2];
    logic                      wr_ptr, rd_ptr, pop;
    logic [1:0]                count;

    // accept depends only on registered occupancy, breaking out_ready -> in_ready
    assign accept_ok = !count[1];
    assign pop       = out_ready && count != 2'd0;
    assign out_valid = count != 2'd0;
    assign data_out  = fifo_d[rd_ptr];
    assign out_id    = fifo_id[rd_ptr];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fifo_d[0]  <= '0;
            fifo_d[1]  <= '0;
            fifo_id[0] <= '0;
            fifo_id[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (xfer) begin
                fifo_d[wr_ptr]  <= sum_res;
                fifo_id[wr_ptr] <= cand;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(xfer) - 2'(pop);
        end
`else
    assign accept_ok = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            out_id    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            data_out  <= sum_res;
            out_id    <= cand;
        end else if (out_ready)
            out_valid <= 1'b0;
`endif
endmodule
